// File: rtl/vmmu_ts.sv
// vmmu_ts: programmable time-slot arbiter multiplexing address sources, read
// destinations and one write channel onto the async SRAM port. Optional macro: VMMU_TS_SKIP_NOP_EN.
//
// phase       | meaning
// PH_SETUP    | fetch slot entry, drive address, assert OE or WE
// PH_ACCESS   | capture read data / ack write, release strobes, advance slot
`timescale 1ns/1ps
module vmmu_ts #(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 8,
  parameter int NSRC   = 4,
  parameter int NRD    = 2,
  parameter int TSLOTS = 8,
  parameter int TIDX   = $clog2(TSLOTS)
) (
  input  logic                    MemClk,
  input  logic                    MemRstN,
  input  logic [NSRC*AWIDTH-1:0]  ReqAddr,
  input  logic [DWIDTH-1:0]       ReqWriteData,
  output logic                    WriteAck,
  output logic [NRD*DWIDTH-1:0]   ReqReadData,
  output logic [NRD-1:0]          ReadDataRdy,
  input  logic                    SlotWrEn,
  input  logic [TIDX-1:0]         SlotWrIdx,
  input  logic [7:0]              SlotWrData,
  output logic [TIDX-1:0]         SlotIndex,
  output logic                    FrameStart,
  output logic [AWIDTH-1:0]       MemAddrPort,
  inout  wire  [DWIDTH-1:0]       MemDataPort,
  output logic                    MemWriteEnable,
  output logic                    MemOutputEnable
);

  localparam logic [0:0] PH_SETUP  = 1'b0;
  localparam logic [0:0] PH_ACCESS = 1'b1;

  logic [7:0]            slot_tab [TSLOTS];
  logic [0:0]            phase;
  logic [TIDX-1:0]       slot_idx, slot_nxt;
  logic [7:0]            fetch;
  logic [2:0]            f_src, f_dst;
  logic                  f_wr, f_nop;
  logic                  cur_wr, cur_nop;
  logic [2:0]            cur_dst;
  logic [AWIDTH-1:0]     mem_addr;
  logic                  we_n, oe_n;
  logic [DWIDTH-1:0]     drv_data;
  logic [NRD*DWIDTH-1:0] rd_data;
  logic [NRD-1:0]        rdy;
  logic                  ack, frame_start;

  // Out-of-range source, or read to a missing destination, degrades to NOP.
  always_comb begin
    fetch    = slot_tab[slot_idx];
    f_src    = fetch[6:4];
    f_dst    = fetch[3:1];
    f_wr     = fetch[0];
    f_nop    = fetch[7] | (32'(f_src) >= NSRC) | (!f_wr && (32'(f_dst) >= NRD));
    slot_nxt = (slot_idx == TIDX'(TSLOTS - 1)) ? '0 : slot_idx + 1'b1;
  end

  always_ff @(posedge MemClk or negedge MemRstN) begin
    if (!MemRstN) begin
      for (int i = 0; i < TSLOTS; i++) slot_tab[i] <= 8'h80;
    end else if (SlotWrEn && (32'(SlotWrIdx) < TSLOTS)) begin
      slot_tab[SlotWrIdx] <= SlotWrData;
    end
  end

  always_ff @(posedge MemClk or negedge MemRstN) begin
    if (!MemRstN) begin
      phase       <= PH_SETUP;
      slot_idx    <= '0;
      cur_wr      <= 1'b0;
      cur_nop     <= 1'b1;
      cur_dst     <= '0;
      mem_addr    <= '0;
      we_n        <= 1'b1;
      oe_n        <= 1'b1;
      drv_data    <= '0;
      rd_data     <= '0;
      rdy         <= '0;
      ack         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rdy         <= '0;
      ack         <= 1'b0;
      frame_start <= 1'b0;
      if (phase == PH_SETUP) begin
        cur_wr  <= f_wr;
        cur_dst <= f_dst;
        cur_nop <= f_nop;
        if (!f_nop) begin
          mem_addr <= ReqAddr[32'(f_src)*AWIDTH +: AWIDTH];
          if (f_wr) begin
            drv_data <= ReqWriteData;
            we_n     <= 1'b0;
          end else begin
            oe_n <= 1'b0;
          end
        end
`ifdef VMMU_TS_SKIP_NOP_EN
        if (f_nop) begin
          slot_idx    <= slot_nxt;
          frame_start <= (slot_nxt == '0);
        end else begin
          phase <= PH_ACCESS;
        end
`else
        phase <= PH_ACCESS;
`endif
      end else begin
        if (!cur_nop) begin
          if (cur_wr) begin
            ack <= 1'b1;
          end else begin
            rd_data[32'(cur_dst)*DWIDTH +: DWIDTH] <= MemDataPort;
            rdy <= NRD'(1) << cur_dst;
          end
        end
        we_n        <= 1'b1;
        oe_n        <= 1'b1;
        phase       <= PH_SETUP;
        slot_idx    <= slot_nxt;
        frame_start <= (slot_nxt == '0);
      end
    end
  end

  // Driver enable is tied to WE so the bus can never be driven during a read.
  assign MemDataPort     = (!we_n) ? drv_data : 'z;
  assign MemAddrPort     = mem_addr;
  assign MemWriteEnable  = we_n;
  assign MemOutputEnable = oe_n;
  assign ReqReadData     = rd_data;
  assign ReadDataRdy     = rdy;
  assign WriteAck        = ack;
  assign FrameStart      = frame_start;
  assign SlotIndex       = slot_idx;

endmodule

// File: doc/vmmu_ts.md
Name: vmmu_ts

Overview:
- Parametrised time-slot memory arbiter for the external asynchronous SRAM; successor to the fixed 8-slot vmmu.
- Multiplexes NSRC address sources and NRD read destinations, plus one write channel with acknowledge, onto a single SRAM port.
- The slot table is runtime-programmable and resets to all-NOP.
- Sits between the VGA scan-out, CPU and blitter request logic and the SRAM pads.

Parameters:
- AWIDTH, 19, SRAM address width
- DWIDTH, 8, SRAM data width
- NSRC, 4, number of address sources (1..8)
- NRD, 2, number of read destinations (1..8)
- TSLOTS, 8, slot table depth (2..256, power of two not required)
- TIDX, $clog2(TSLOTS), slot index width (derived)

Ports:
- MemClk  in  1  memory clock, all logic on rising edge
- MemRstN  in  1  asynchronous active-low reset
- ReqAddr  in  NSRC*AWIDTH  packed source addresses, source k at [k*AWIDTH +: AWIDTH]
- ReqWriteData  in  DWIDTH  write data for write slots
- WriteAck  out  1  1-cycle pulse: ReqWriteData consumed
- ReqReadData  out  NRD*DWIDTH  packed read-data registers, one per destination
- ReadDataRdy  out  NRD  per-destination 1-cycle valid pulse
- SlotWrEn  in  1  slot table write strobe
- SlotWrIdx  in  TIDX  slot table write index
- SlotWrData  in  8  slot table entry
- SlotIndex  out  TIDX  index of slot currently in setup/access
- FrameStart  out  1  1-cycle pulse in setup cycle of slot 0
- MemAddrPort  out  AWIDTH  SRAM address
- MemDataPort  inout  DWIDTH  SRAM data, tri-stated unless writing
- MemWriteEnable  out  1  SRAM WE, active low
- MemOutputEnable  out  1  SRAM OE, active low

Behaviour:
- Slot entry format:
  - bit7 NOP
  - bits6:4 source index
  - bits3:1 destination index
  - bit0 R/W (1 = write)
  - A source index >= NSRC, or a read with destination >= NRD, is treated as NOP.
- Reset values:
  - Table: all entries 8'h80.
  - Phase 0, SlotIndex 0, MemAddrPort 0, ReqReadData 0.
  - MemWriteEnable 1, MemOutputEnable 1.
  - Data bus released; ReadDataRdy, WriteAck, FrameStart all 0.
- Each slot occupies 2 cycles, SETUP (phase 0) then ACCESS (phase 1).
- SETUP edge:
  - Register entry Table[SlotIndex] into CurSlot.
  - Non-NOP: MemAddrPort <= ReqAddr[src].
  - Read: MemOutputEnable <= 0.
  - Write: latch ReqWriteData into the drive register, enable the bus driver, MemWriteEnable <= 0.
  - NOP: address, WE and OE unchanged (idle).
- ACCESS edge:
  - Read: ReqReadData[dst] <= MemDataPort, ReadDataRdy[dst] <= 1.
  - Write: WriteAck <= 1.
  - Then MemWriteEnable <= 1, MemOutputEnable <= 1, bus driver off, in the same edge.
  - SlotIndex <= SlotIndex+1, wrapping TSLOTS-1 -> 0.
- Latency: read data and Rdy are valid 2 cycles after the setup cycle begins. ReqReadData holds its value until the next read to that destination.
- Table write:
  - Takes effect at the clock edge.
  - A write to slot i is seen if it lands at or before the edge that begins i's SETUP. Same-edge write-and-fetch of the same index uses the old entry.
  - A write to the slot currently in ACCESS does not alter that access.
- WE and OE are never both 0. The data driver is enabled only while MemWriteEnable = 0.
- Reset mid-access forces WE/OE high and releases the bus immediately (asynchronous). The table is reinitialised to NOP.

Optional Feature:
- VMMU_TS_SKIP_NOP_EN
  - Defined: a NOP slot consumes 1 cycle only. Its SETUP edge advances SlotIndex directly and phase stays 0; a frame of k NOPs is shortened by k cycles.
  - Undefined: NOP slots take 2 idle cycles and frame length is fixed at 2*TSLOTS.
  - FrameStart still pulses at every slot-0 setup in both cases.

Test Plan:
- Reset release, table untouched -> WE=OE=1, bus Z, no Rdy/Ack. FrameStart every 16 cycles (TSLOTS=8); every 8 cycles with SKIP_NOP.
- Program slot0 = 8'h10 (read, src1, dst0), ReqAddr src1 = 19'h01234, SRAM model returns 8'hA5 -> MemAddrPort = 19'h01234 with OE=0 for 1 cycle; ReqReadData[0] = 8'hA5 and ReadDataRdy = 2'b01 the cycle after.
- Program slot3 = 8'h21 (write, src2), ReqWriteData = 8'h3C -> WE=0 for 1 cycle, bus = 8'h3C, WriteAck pulse. A later read of the same address returns 8'h3C.
- Entries with src=5 (NSRC=4) or read dst=3 (NRD=2) -> no WE/OE activity, no Rdy pulse.
- Rewrite slot2 at the same edge as its fetch -> old entry used this frame, new entry used next frame.
- Assert MemRstN low during a write ACCESS -> WE=1 and bus Z before the next edge; table reads back as NOP after release.
